sram_lsu: RTL and testbench
===========================

Name: sram_lsu

Overview:
- Load/store initiator that drives the single-port SRAM bus (CS/WE/addr/data_in, registered data_out) on behalf of the CPU datapath.
- Accepts byte-addressed load/store requests of byte, half-word or word size over a valid/ready handshake.
- Issues word-wide SRAM cycles, including a read-modify-write for sub-word stores, since the SRAM has no byte enables.
- Returns sign- or zero-extended load data over a valid/ready response channel.

Parameters:
- ADDR, 8: SRAM word-address width; CPU byte address is ADDR+2 bits.
- WIDTH, 32: data width. Only 32 is supported: 4 byte lanes, little-endian.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR+2  byte address.
- req_wdata  in  WIDTH  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  WIDTH  extended load data; 0 for stores.
- resp_err  out  1  misaligned or illegal-size request.
- mem_cs  out  1  SRAM chip select.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR  SRAM word address = req_addr[ADDR+1:2].
- mem_wdata  out  WIDTH  SRAM write data.
- mem_rdata  in  WIDTH  SRAM registered read data.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE: req_ready=1. Accept on req_valid&&req_ready and register all request fields. req_ready=0 in every other state (one outstanding request).
- Next state from IDLE on accept:
  - error -> RESP
  - word store -> WRITE
  - load or sub-word store -> READ
- READ: mem_cs=1, mem_we=0, mem_addr driven. Next state WAIT.
- WAIT: mem_rdata is valid this cycle and is captured at the closing edge.
  - Load: extract lane at offset addr[1:0], extend per size/unsigned into resp_rdata -> RESP.
  - Sub-word store: merge req_wdata low byte/half into the captured word at the offset lane -> WRITE.
- WRITE: mem_cs=1, mem_we=1, mem_wdata = merged word (or req_wdata for a word store). Next state RESP.
- RESP: resp_valid=1; resp_rdata and resp_err stable. Leave to IDLE on resp_ready. Hold indefinitely otherwise.
- mem_* outputs decode from flops only, with no combinational path from req_* inputs. mem_cs is 0 in all states except READ and WRITE.
- Latency from the accept edge to resp_valid high:
  - load: 3 cycles
  - word store: 2 cycles
  - sub-word store: 4 cycles
  - error: 1 cycle
- Back-to-back: the next request can be accepted in the cycle after the RESP handshake.
- Error conditions: size 11; half with addr[0]=1; word with addr[1:0]!=0.
- rst in any state: return to IDLE, drop the pending response. mem_cs is forced to 0 while rst=1, so no SRAM write occurs during a reset cycle, including one taken in WRITE.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: error detection as above. An erroring request makes no SRAM access and returns resp_err=1, resp_rdata=0.
- Undefined: resp_err is tied 0, and size 11 is treated as word. Misaligned half forces addr[0]=0; misaligned word forces addr[1:0]=0. The access then proceeds normally.

Decomposition:
- Package lsu_pkg holds:
  - state encoding constants (IDLE, READ, WAIT, WRITE, RESP)
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
- Sub-module lsu_lane_align (combinational): load extract/extend and store merge, keyed on offset, size and unsigned.

Test Plan:
- Common setup: preload mem[4]=0x8899AABB.
- Signed byte load, addr 0x12 -> resp_rdata=0xFFFFFF99, resp_valid 3 cycles after accept, mem_cs high for exactly 1 cycle with mem_we=0.
- Unsigned half load, addr 0x12 -> resp_rdata=0x00008899. Signed half load, addr 0x10 -> 0xFFFFAABB.
- Half store 0x00001234, addr 0x10 -> READ then WRITE with mem_addr=4, mem_wdata=0x88991234, resp_valid at cycle 4. A following word load of 0x10 returns 0x88991234.
- Word store 0xDEADBEEF, addr 0x20 -> single write cycle to mem[8], resp at cycle 2. Hold resp_ready=0 for 5 cycles: resp_valid stays 1 and req_ready stays 0. A back-to-back load of 0x20 returns 0xDEADBEEF.
- Word load, addr 0x11:
  - with LSU_ALIGN_CHECK_EN: resp_err=1 at cycle 1, mem_cs never asserted
  - without it: reads mem[4], returns 0x8899AABB, resp_err=0
- Assert rst while in WAIT during a byte store to addr 0x13 -> next cycle IDLE, req_ready=1, resp_valid=0, no write cycle, mem[4] unchanged.

Source files
------------

// File: rtl/sram_lsu_pkg.sv
// Shared constants and request-control struct for the SRAM load/store unit.
package lsu_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic       err;
  } req_ctl_t;
endpackage

// File: rtl/sram_lsu_if.sv
// CPU request/response channel plus SRAM bus, bundled for the load/store unit.
interface sram_lsu_if #(parameter int ADDR = 8, parameter int WIDTH = 32) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [ADDR+1:0]  req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;
  logic             mem_cs;
  logic             mem_we;
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_cs, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_lsu_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge into a read word.
module lsu_lane_align import lsu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rword_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [1:0]       off_i,
  input  logic [1:0]       size_i,
  input  logic             uns_i,
  output logic [WIDTH-1:0] ld_data_o,
  output logic [WIDTH-1:0] st_word_o
);
  localparam int NUM_LANES = WIDTH / 8;

  logic [WIDTH-1:0]     shr;
  logic [WIDTH-1:0]     shl;
  logic [NUM_LANES-1:0] be;

  assign shr = rword_i >> {off_i, 3'b000};
  assign shl = wdata_i << {off_i, 3'b000};

  always_comb begin
    ld_data_o = shr;
    be        = '1;
    case (size_i)
      SZ_BYTE: begin
        ld_data_o = {{(WIDTH-8){shr[7] & ~uns_i}}, shr[7:0]};
        be        = {{(NUM_LANES-1){1'b0}}, 1'b1} << off_i;
      end
      SZ_HALF: begin
        ld_data_o = {{(WIDTH-16){shr[15] & ~uns_i}}, shr[15:0]};
        be        = {{(NUM_LANES-2){1'b0}}, 2'b11} << off_i;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign st_word_o[8*i +: 8] = be[i] ? shl[8*i +: 8] : rword_i[8*i +: 8];
  end
endmodule

// File: rtl/sram_lsu.sv
// Load/store initiator for a single-port SRAM without byte enables.
// LSU_ALIGN_CHECK_EN: flag misaligned/illegal requests instead of force-aligning them.
module sram_lsu import lsu_pkg::*; #(
  parameter int ADDR  = 8,
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  sram_lsu_if.slave  bus_io
);
  logic [2:0]       state_q, state_d;
  req_ctl_t         ctl_q, ctl_d;
  logic [ADDR+1:0]  addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]       size_n;
  logic [ADDR+1:0]  addr_n;
  logic             err_n;
  logic [WIDTH-1:0] ld_data, st_word;

  always_comb begin
    size_n = bus_io.req_size;
    addr_n = bus_io.req_addr;
    err_n  = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    err_n = (bus_io.req_size == 2'b11) ||
            (bus_io.req_size == SZ_HALF && bus_io.req_addr[0]) ||
            (bus_io.req_size == SZ_WORD && bus_io.req_addr[1:0] != 2'b00);
`else
    if (size_n == 2'b11) size_n = SZ_WORD;
    if (size_n == SZ_HALF) addr_n[0] = 1'b0;
    if (size_n == SZ_WORD) addr_n[1:0] = 2'b00;
`endif
  end

  lsu_lane_align #(.WIDTH(WIDTH)) u_align (
    .rword_i   (bus_io.mem_rdata),
    .wdata_i   (wdata_q),
    .off_i     (addr_q[1:0]),
    .size_i    (ctl_q.size),
    .uns_i     (ctl_q.uns),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  // wdata_q holds the store data until WAIT, then the merged word for WRITE
  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (bus_io.req_valid) begin
        ctl_d   = '{we: bus_io.req_we, size: size_n, uns: bus_io.req_unsigned, err: err_n};
        addr_d  = addr_n;
        wdata_d = bus_io.req_wdata;
        rdata_d = '0;
        if (err_n)                                   state_d = S_RESP;
        else if (bus_io.req_we && size_n == SZ_WORD) state_d = S_WRITE;
        else                                         state_d = S_READ;
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        if (ctl_q.we) begin
          wdata_d = st_word;
          state_d = S_WRITE;
        end else begin
          rdata_d = ld_data;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (bus_io.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_io.req_ready  = (state_q == S_IDLE);
  assign bus_io.resp_valid = (state_q == S_RESP);
  assign bus_io.resp_rdata = rdata_q;
  assign bus_io.resp_err   = ctl_q.err;
  // rst gates the strobes so a reset taken in WRITE never reaches the array
  assign bus_io.mem_cs     = ((state_q == S_READ) || (state_q == S_WRITE)) && !rst;
  assign bus_io.mem_we     = (state_q == S_WRITE) && !rst;
  assign bus_io.mem_addr   = addr_q[ADDR+1:2];
  assign bus_io.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_sram_lsu.sv
// Self-checking bench for sram_lsu: directed cases plus randomized traffic vs. a byte-level model.
module tb_sram_lsu;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  sram_lsu_if #(.ADDR(8), .WIDTH(32)) bif ();
  sram_lsu #(.ADDR(8), .WIDTH(32)) dut (.clk(clk), .rst(rst), .bus_io(bif.slave));

  always #5 clk = ~clk;

  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  int          cs_cnt = 0;
  int          wr_cnt = 0;
  logic [7:0]  last_waddr;
  logic [31:0] last_wdata;

  always @(posedge clk) begin
    if (bif.mem_cs) begin
      cs_cnt++;
      if (bif.mem_we) begin
        tb_mem[bif.mem_addr] <= bif.mem_wdata;
        last_waddr = bif.mem_addr;
        last_wdata = bif.mem_wdata;
        wr_cnt++;
      end else begin
        bif.mem_rdata <= tb_mem[bif.mem_addr];
      end
    end
  end

  function automatic logic [7:0] rbyte(input logic [9:0] a);
    logic [31:0] w;
    w = ref_mem[a[9:2]] >> (8 * int'(a[1:0]));
    return w[7:0];
  endfunction

  task automatic wbyte(input logic [9:0] a, input logic [7:0] b);
    int sh;
    sh = 8 * int'(a[1:0]);
    ref_mem[a[9:2]] = (ref_mem[a[9:2]] & ~(32'hFF << sh)) | ({24'b0, b} << sh);
  endtask

  // Reference: byte-addressed memory semantics, updates ref_mem for completed stores
  task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [9:0] a,
                       input logic [31:0] wd, output logic [31:0] erd, output logic eer,
                       output int elat, output int ecs, output int ewr);
    int n;
    logic [9:0] ea;
    logic [1:0] es;
    logic [31:0] v;
    es = sz; ea = a; eer = 1'b0; erd = '0;
`ifdef LSU_ALIGN_CHECK_EN
    eer = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
    if (es == 2'd3) es = 2'd2;
    if (es == 2'd1) ea[0] = 1'b0;
    if (es == 2'd2) ea[1:0] = 2'd0;
`endif
    n = (es == 2'd0) ? 1 : (es == 2'd1) ? 2 : 4;
    if (eer) begin
      elat = 1; ecs = 0; ewr = 0;
    end else if (!we) begin
      v = '0;
      for (int k = 0; k < n; k++) v = v | ({24'b0, rbyte(ea + 10'(k))} << (8 * k));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      erd = v; elat = 3; ecs = 1; ewr = 0;
    end else begin
      for (int k = 0; k < n; k++) begin
        v = wd >> (8 * k);
        wbyte(ea + 10'(k), v[7:0]);
      end
      elat = (n == 4) ? 2 : 4; ecs = (n == 4) ? 1 : 2; ewr = 1;
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [9:0] a,
                       input logic [31:0] wd, output int lat, output int ncs, output int nwr,
                       output logic [31:0] rd, output logic er);
    int cs0, wr0;
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = we; bif.req_size = sz;
    bif.req_unsigned = uns; bif.req_addr = a; bif.req_wdata = wd;
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    cs0 = cs_cnt; wr0 = wr_cnt; lat = 1;
    while (!bif.resp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    ncs = cs_cnt - cs0; nwr = wr_cnt - wr0;
    rd = bif.resp_rdata; er = bif.resp_err;
  endtask

  task automatic release_resp();
    @(negedge clk);
    bif.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bif.req_ready !== 1'b1 || bif.resp_valid !== 1'b0 || bif.resp_rdata !== 32'h0 ||
        bif.resp_err !== 1'b0 || bif.mem_cs !== 1'b0 || bif.mem_we !== 1'b0 ||
        bif.mem_addr !== 8'h0 || bif.mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b rd=%h err=%b cs=%b we=%b addr=%h wd=%h required rdy=1 others 0",
               bif.req_ready, bif.resp_valid, bif.resp_rdata, bif.resp_err, bif.mem_cs,
               bif.mem_we, bif.mem_addr, bif.mem_wdata);
    end
  endtask

  task automatic test_loads();
    int lat, ncs, nwr, el, ec, ew;
    logic [31:0] rd, erd;
    logic er, eer;
    model(1'b0, 2'd0, 1'b0, 10'h12, 32'h0, erd, eer, el, ec, ew);
    issue(1'b0, 2'd0, 1'b0, 10'h12, 32'h0, lat, ncs, nwr, rd, er);
    checks++;
    if (rd !== 32'hFFFF_FF99) begin failures++; $display("FAIL sbyte_data: got %h required %h", rd, 32'hFFFF_FF99); end
    checks++;
    if (lat != 3) begin failures++; $display("FAIL sbyte_latency: got %0d required 3", lat); end
    checks++;
    if (ncs != 1 || nwr != 0) begin failures++; $display("FAIL sbyte_cs: cs=%0d wr=%0d required 1/0", ncs, nwr); end
    release_resp();
    model(1'b0, 2'd1, 1'b1, 10'h12, 32'h0, erd, eer, el, ec, ew);
    issue(1'b0, 2'd1, 1'b1, 10'h12, 32'h0, lat, ncs, nwr, rd, er);
    checks++;
    if (rd !== 32'h0000_8899) begin failures++; $display("FAIL uhalf_data: got %h required %h", rd, 32'h0000_8899); end
    release_resp();
    model(1'b0, 2'd1, 1'b0, 10'h10, 32'h0, erd, eer, el, ec, ew);
    issue(1'b0, 2'd1, 1'b0, 10'h10, 32'h0, lat, ncs, nwr, rd, er);
    checks++;
    if (rd !== 32'hFFFF_AABB) begin failures++; $display("FAIL shalf_data: got %h required %h", rd, 32'hFFFF_AABB); end
    release_resp();
  endtask

  task automatic test_misaligned();
    int lat, ncs, nwr, el, ec, ew;
    logic [31:0] rd, erd;
    logic er, eer;
    model(1'b0, 2'd2, 1'b0, 10'h11, 32'h0, erd, eer, el, ec, ew);
    issue(1'b0, 2'd2, 1'b0, 10'h11, 32'h0, lat, ncs, nwr, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || ncs != 0) begin
      failures++;
      $display("FAIL misaligned_err: err=%b rd=%h lat=%0d cs=%0d required 1/0/1/0", er, rd, lat, ncs);
    end
`else
    checks++;
    if (er !== 1'b0 || rd !== 32'h8899_AABB || lat != 3 || ncs != 1) begin
      failures++;
      $display("FAIL misaligned_fix: err=%b rd=%h lat=%0d cs=%0d required 0/8899aabb/3/1", er, rd, lat, ncs);
    end
`endif
    release_resp();
  endtask

  task automatic test_half_store();
    int lat, ncs, nwr, el, ec, ew;
    logic [31:0] rd, erd;
    logic er, eer;
    model(1'b1, 2'd1, 1'b0, 10'h10, 32'h0000_1234, erd, eer, el, ec, ew);
    issue(1'b1, 2'd1, 1'b0, 10'h10, 32'h0000_1234, lat, ncs, nwr, rd, er);
    checks++;
    if (lat != 4 || ncs != 2 || nwr != 1) begin
      failures++; $display("FAIL hstore_timing: lat=%0d cs=%0d wr=%0d required 4/2/1", lat, ncs, nwr);
    end
    checks++;
    if (last_waddr !== 8'd4 || last_wdata !== 32'h8899_1234 || rd !== 32'h0) begin
      failures++; $display("FAIL hstore_write: addr=%h data=%h rd=%h required 04/88991234/0", last_waddr, last_wdata, rd);
    end
    release_resp();
    model(1'b0, 2'd2, 1'b0, 10'h10, 32'h0, erd, eer, el, ec, ew);
    issue(1'b0, 2'd2, 1'b0, 10'h10, 32'h0, lat, ncs, nwr, rd, er);
    checks++;
    if (rd !== 32'h8899_1234) begin failures++; $display("FAIL hstore_readback: got %h required %h", rd, 32'h8899_1234); end
    release_resp();
  endtask

  task automatic test_back_to_back();
    int lat, ncs, nwr, el, ec, ew;
    logic [31:0] rd, erd;
    logic er, eer;
    model(1'b1, 2'd2, 1'b0, 10'h20, 32'hDEAD_BEEF, erd, eer, el, ec, ew);
    issue(1'b1, 2'd2, 1'b0, 10'h20, 32'hDEAD_BEEF, lat, ncs, nwr, rd, er);
    checks++;
    if (lat != 2 || ncs != 1 || nwr != 1 || last_waddr !== 8'd8 || last_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wstore: lat=%0d cs=%0d wr=%0d addr=%h data=%h required 2/1/1/08/deadbeef",
               lat, ncs, nwr, last_waddr, last_wdata);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bif.resp_valid !== 1'b1 || bif.req_ready !== 1'b0) begin
        failures++; $display("FAIL resp_hold: cycle %0d vld=%b rdy=%b required 1/0", i, bif.resp_valid, bif.req_ready);
      end
    end
    release_resp();
    checks++;
    if (bif.req_ready !== 1'b1 || bif.resp_valid !== 1'b0) begin
      failures++; $display("FAIL after_handshake: rdy=%b vld=%b required 1/0", bif.req_ready, bif.resp_valid);
    end
    model(1'b0, 2'd2, 1'b0, 10'h20, 32'h0, erd, eer, el, ec, ew);
    issue(1'b0, 2'd2, 1'b0, 10'h20, 32'h0, lat, ncs, nwr, rd, er);
    checks++;
    if (rd !== 32'hDEAD_BEEF || lat != 3) begin
      failures++; $display("FAIL b2b_load: got %h lat=%0d required deadbeef/3", rd, lat);
    end
    release_resp();
  endtask

  task automatic test_reset_mid();
    int cs0, wr0;
    logic [31:0] m4, m9;
    m4 = tb_mem[4];
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_size = 2'd0;
    bif.req_unsigned = 1'b0; bif.req_addr = 10'h13; bif.req_wdata = 32'h55;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    @(posedge clk); #1;
    cs0 = cs_cnt; wr0 = wr_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bif.req_ready !== 1'b1 || bif.resp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_in_wait: rdy=%b vld=%b required 1/0", bif.req_ready, bif.resp_valid);
    end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (cs_cnt != cs0 || wr_cnt != wr0 || tb_mem[4] !== m4) begin
      failures++; $display("FAIL reset_no_write: cs=%0d wr=%0d mem4=%h required 0/0/%h", cs_cnt - cs0, wr_cnt - wr0, tb_mem[4], m4);
    end
    // reset raised during the WRITE cycle itself
    m9 = tb_mem[9];
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_size = 2'd2;
    bif.req_addr = 10'h24; bif.req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    wr0 = wr_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if (bif.mem_cs !== 1'b0) begin failures++; $display("FAIL cs_gated: got %b required 0", bif.mem_cs); end
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wr_cnt != wr0 || tb_mem[9] !== m9 || bif.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_write: wr=%0d mem9=%h rdy=%b required 0/%h/1", wr_cnt - wr0, tb_mem[9], bif.req_ready, m9);
    end
  endtask

  task automatic test_random();
    int lat, ncs, nwr, el, ec, ew, bad;
    logic [31:0] rd, erd, wd;
    logic er, eer, we, uns;
    logic [1:0] sz;
    logic [9:0] a;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(1)); sz = 2'($urandom_range(3)); uns = 1'($urandom_range(1));
      a = 10'($urandom); wd = $urandom;
      model(we, sz, uns, a, wd, erd, eer, el, ec, ew);
      issue(we, sz, uns, a, wd, lat, ncs, nwr, rd, er);
      checks++;
      if (rd !== erd || er !== eer || lat != el || ncs != ec || nwr != ew) begin
        failures++;
        $display("FAIL rand_%0d: we=%b sz=%0d u=%b a=%h rd=%h err=%b lat=%0d cs=%0d wr=%0d required rd=%h err=%b lat=%0d cs=%0d wr=%0d",
                 i, we, sz, uns, a, rd, er, lat, ncs, nwr, erd, eer, el, ec, ew);
      end
      repeat ($urandom_range(2)) @(posedge clk);
      release_resp();
    end
    bad = 0;
    for (int j = 0; j < 256; j++) if (tb_mem[j] !== ref_mem[j]) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL mem_image: %0d words differ, required 0", bad); end
  endtask

  initial begin
    for (int j = 0; j < 256; j++) begin
      tb_mem[j] = $urandom;
      ref_mem[j] = tb_mem[j];
    end
    tb_mem[4] = 32'h8899_AABB; ref_mem[4] = 32'h8899_AABB;
    bif.mem_rdata = '0;
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_size = 2'd0; bif.req_unsigned = 1'b0;
    bif.req_addr = '0; bif.req_wdata = '0; bif.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_loads();
    test_misaligned();
    test_half_store();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
